// File: rtl/alarma_uart_tx_if.sv
// Signal bundle between the alarm core (master) and the UART notifier (slave).
interface alarma_uart_tx_if;
  logic       ev_gas;
  logic       ev_mov;
  logic       ev_clave;
  logic       tx;
  logic       ocupado;
  logic [7:0] enviados;

  modport master (output ev_gas, ev_mov, ev_clave, input tx, ocupado, enviados);
  modport slave  (input ev_gas, ev_mov, ev_clave, output tx, ocupado, enviados);
endinterface

// File: rtl/alarma_uart_tx.sv
// Alarm-event UART notifier: edge-detects gas/motion/disarm events and sends a 5-byte ASCII notice each.
// Optional even parity bit per byte when ALARMA_UART_PARITY_EN is defined (default: plain 8N1).
module alarma_uart_tx #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic             clk,
  input  logic             rst_n,
  alarma_uart_tx_if.slave  bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef ALARMA_UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // Message ROM: index 0 = gas, 1 = motion, 2 = disarm; bytes 3/4 are CR LF.
  function automatic logic [7:0] msg_byte(input logic [1:0] msg, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h0A;
    case (idx)
      3'd0: case (msg) 2'd0: b = 8'h47; 2'd1: b = 8'h4D; default: b = 8'h4F; endcase
      3'd1: case (msg) 2'd0: b = 8'h41; 2'd1: b = 8'h4F; default: b = 8'h46; endcase
      3'd2: case (msg) 2'd0: b = 8'h53; 2'd1: b = 8'h56; default: b = 8'h46; endcase
      3'd3: b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

`ifdef ALARMA_UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
  logic parity_r;
`endif

  logic [2:0]    state_r;
  logic [2:0]    prev_r, pend_r;
  logic [2:0]    cur_s, rise_s, sel_mask_s;
  logic [1:0]    sel_s, msg_r;
  logic          take_s, bit_end_s;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r, byte_idx_r;
  logic [7:0]    shreg_r, enviados_r;
  logic          tx_r, ocupado_r;

  assign cur_s     = {bus.ev_clave, bus.ev_mov, bus.ev_gas};
  assign rise_s    = cur_s & ~prev_r;
  assign take_s    = (state_r == IDLE) && (|pend_r);
  assign bit_end_s = (baud_cnt_r == LAST);

  // Fixed-priority pick of the next pending event: gas > mov > clave.
  always_comb begin
    sel_s      = 2'd0;
    sel_mask_s = 3'b000;
    if (pend_r[0]) begin
      sel_s      = 2'd0;
      sel_mask_s = 3'b001;
    end else if (pend_r[1]) begin
      sel_s      = 2'd1;
      sel_mask_s = 3'b010;
    end else if (pend_r[2]) begin
      sel_s      = 2'd2;
      sel_mask_s = 3'b100;
    end else begin
      sel_s      = 2'd0;
      sel_mask_s = 3'b000;
    end
  end

  // Edge history and pending flags; a same-cycle edge of the event being taken re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 3'b000;
      pend_r <= 3'b000;
    end else begin
      prev_r <= cur_s;
      pend_r <= (pend_r & ~(take_s ? sel_mask_s : 3'b000)) | rise_s;
    end
  end

  // Transmit FSM with registered line, busy flag and message counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tx_r       <= 1'b1;
      ocupado_r  <= 1'b0;
      enviados_r <= 8'd0;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      msg_r      <= 2'd0;
      shreg_r    <= 8'd0;
`ifdef ALARMA_UART_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            msg_r      <= sel_s;
            byte_idx_r <= 3'd0;
            shreg_r    <= msg_byte(sel_s, 3'd0);
`ifdef ALARMA_UART_PARITY_EN
            parity_r   <= even_parity(msg_byte(sel_s, 3'd0));
`endif
            baud_cnt_r <= '0;
            tx_r       <= 1'b0;
            ocupado_r  <= 1'b1;
            state_r    <= START;
          end else begin
            tx_r      <= 1'b1;
            ocupado_r <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            tx_r       <= shreg_r[0];
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
`ifdef ALARMA_UART_PARITY_EN
              tx_r    <= parity_r;
              state_r <= PARITY;
`else
              tx_r    <= 1'b1;
              state_r <= STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shreg_r   <= {1'b0, shreg_r[7:1]};
              tx_r      <= shreg_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
`ifdef ALARMA_UART_PARITY_EN
        PARITY: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
            state_r    <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (byte_idx_r < 3'd4) begin
              byte_idx_r <= byte_idx_r + 3'd1;
              shreg_r    <= msg_byte(msg_r, byte_idx_r + 3'd1);
`ifdef ALARMA_UART_PARITY_EN
              parity_r   <= even_parity(msg_byte(msg_r, byte_idx_r + 3'd1));
`endif
              tx_r       <= 1'b0;
              state_r    <= START;
            end else begin
              enviados_r <= enviados_r + 8'd1;
              tx_r       <= 1'b1;
              ocupado_r  <= 1'b0;
              state_r    <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        default: begin
          tx_r      <= 1'b1;
          ocupado_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = tx_r;
  assign bus.ocupado  = ocupado_r;
  assign bus.enviados = enviados_r;
endmodule
